// File: rtl/uart_debug_server_engine.sv
// uart_debug_server_engine: UART byte-frame debug server (ACK/READ/WRITE/EXEC).
// Bridges UART RX/TX byte streams to a byte-wide req/gnt/rvalid memory master
// and an execution launch/done handshake.
// Optional feature: UART_DBG_TIMEOUT_EN adds an inter-byte RX timeout that
// aborts partially received frames back to IDLE.
module uart_debug_server_engine #(
    parameter int AddrBytes     = 8,
    parameter int LenBytes      = 8,
    parameter int ExitBytes     = 4,
    parameter int TimeoutCycles = 100000
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [7:0]             rx_data_i,
    input  logic                   rx_valid_i,
    output logic                   rx_ready_o,
    output logic [7:0]             tx_data_o,
    output logic                   tx_valid_o,
    input  logic                   tx_ready_i,
    output logic                   mem_req_o,
    input  logic                   mem_gnt_i,
    output logic                   mem_we_o,
    output logic [8*AddrBytes-1:0] mem_addr_o,
    output logic [7:0]             mem_wdata_o,
    input  logic                   mem_rvalid_i,
    input  logic [7:0]             mem_rdata_i,
    output logic                   exec_valid_o,
    output logic [8*AddrBytes-1:0] exec_addr_o,
    input  logic                   exec_done_i,
    input  logic [8*ExitBytes-1:0] exec_code_i,
    output logic                   busy_o
);

    localparam int AW   = 8 * AddrBytes;
    localparam int LW   = 8 * LenBytes;
    localparam int CW   = 8 * ExitBytes;
    localparam int MaxAL = (AddrBytes > LenBytes) ? AddrBytes : LenBytes;
    localparam int MaxB = (MaxAL > ExitBytes) ? MaxAL : ExitBytes;
    localparam int IW   = $clog2(MaxB + 1);

    localparam logic [IW-1:0] ADDR_LAST = IW'(AddrBytes - 1);
    localparam logic [IW-1:0] LEN_LAST  = IW'(LenBytes - 1);
    localparam logic [IW-1:0] CODE_LAST = IW'(ExitBytes - 1);

    localparam logic [7:0] B_ACK   = 8'h06;
    localparam logic [7:0] B_EOT   = 8'h04;
    localparam logic [7:0] B_READ  = 8'h11;
    localparam logic [7:0] B_WRITE = 8'h12;
    localparam logic [7:0] B_EXEC  = 8'h13;
    localparam logic [7:0] B_EOC   = 8'h14;

    localparam logic [1:0] OP_ACK   = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] OP_EXEC  = 2'd3;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_GET_ADDR = 4'd1;
    localparam logic [3:0] S_GET_LEN  = 4'd2;
    localparam logic [3:0] S_GET_EXEC = 4'd3;
    localparam logic [3:0] S_TX_ACK   = 4'd4;
    localparam logic [3:0] S_WR_DATA  = 4'd5;
    localparam logic [3:0] S_WR_REQ   = 4'd6;
    localparam logic [3:0] S_RD_REQ   = 4'd7;
    localparam logic [3:0] S_RD_WAIT  = 4'd8;
    localparam logic [3:0] S_RD_TX    = 4'd9;
    localparam logic [3:0] S_TX_EOT   = 4'd10;
    localparam logic [3:0] S_RUN      = 4'd11;
    localparam logic [3:0] S_TX_EOC   = 4'd12;
    localparam logic [3:0] S_TX_CODE  = 4'd13;

    logic [3:0]    state;
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic [LW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [7:0]    wdata;
    logic [7:0]    rdata;
    logic [CW-1:0] code;

    logic          rx_xfer;
    logic          tx_xfer;
    logic [LW-1:0] cnt_inc;
    logic [AW+7:0] addr_cat;
    logic [LW+7:0] len_cat;
    logic          timeout_abort;

    // Fields arrive LSB first: shift each new byte in at the top so that after
    // the last byte the first one received sits in bits [7:0].
    assign addr_cat = {rx_data_i, addr};
    assign len_cat  = {rx_data_i, len};
    assign cnt_inc  = cnt + LW'(1);

    // RX acceptance and TX presentation decoded from the current state.
    always_comb begin
        rx_ready_o = 1'b0;
        tx_valid_o = 1'b0;
        tx_data_o  = '0;
        case (state)
            S_IDLE, S_GET_ADDR, S_GET_LEN, S_GET_EXEC, S_WR_DATA: rx_ready_o = ~rst_i;
            S_TX_ACK:  begin tx_valid_o = 1'b1; tx_data_o = B_ACK; end
            S_TX_EOT:  begin tx_valid_o = 1'b1; tx_data_o = B_EOT; end
            S_RD_TX:   begin tx_valid_o = 1'b1; tx_data_o = rdata; end
            S_TX_EOC:  begin tx_valid_o = 1'b1; tx_data_o = B_EOC; end
            S_TX_CODE: begin tx_valid_o = 1'b1; tx_data_o = code[7:0]; end
            default: ;
        endcase
    end

    assign rx_xfer      = rx_valid_i & rx_ready_o;
    assign tx_xfer      = tx_valid_o & tx_ready_i;
    assign mem_req_o    = (state == S_RD_REQ) || (state == S_WR_REQ);
    assign mem_we_o     = (state == S_WR_REQ);
    assign mem_addr_o   = addr;
    assign mem_wdata_o  = wdata;
    assign exec_valid_o = (state == S_RUN);
    assign exec_addr_o  = addr;
    assign busy_o       = (state != S_IDLE);

`ifdef UART_DBG_TIMEOUT_EN
    localparam int TW = $clog2(TimeoutCycles + 1);
    logic [TW-1:0] to_cnt;
    logic          timed_state;

    assign timed_state = (state == S_GET_ADDR) || (state == S_GET_LEN) ||
                         (state == S_GET_EXEC) || (state == S_WR_DATA);
    assign timeout_abort = timed_state && !rx_xfer && (to_cnt == '0);

    // Inter-byte watchdog: reloads on every RX byte and outside the waiting states.
    always_ff @(posedge clk_i) begin
        if (rst_i || rx_xfer || !timed_state) begin
            to_cnt <= TW'(TimeoutCycles - 1);
        end else if (to_cnt != '0) begin
            to_cnt <= to_cnt - TW'(1);
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TimeoutCycles == 0);
    assign timeout_abort  = 1'b0;
`endif

    // Frame parser and transfer sequencer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
            op    <= OP_ACK;
            addr  <= '0;
            len   <= '0;
            cnt   <= '0;
            idx   <= '0;
            wdata <= '0;
            rdata <= '0;
            code  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    idx <= '0;
                    if (rx_xfer) begin
                        case (rx_data_i)
                            B_ACK:   begin op <= OP_ACK;   state <= S_TX_ACK;   end
                            B_READ:  begin op <= OP_READ;  state <= S_GET_ADDR; end
                            B_WRITE: begin op <= OP_WRITE; state <= S_GET_ADDR; end
                            B_EXEC:  begin op <= OP_EXEC;  state <= S_GET_EXEC; end
                            default: ;
                        endcase
                    end
                end
                S_GET_ADDR, S_GET_EXEC: begin
                    if (rx_xfer) begin
                        addr <= addr_cat[AW+7:8];
                        if (idx == ADDR_LAST) begin
                            idx   <= '0;
                            state <= (state == S_GET_EXEC) ? S_TX_ACK : S_GET_LEN;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                S_GET_LEN: begin
                    if (rx_xfer) begin
                        len <= len_cat[LW+7:8];
                        if (idx == LEN_LAST) begin
                            idx   <= '0;
                            cnt   <= '0;
                            state <= S_TX_ACK;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                S_TX_ACK: begin
                    if (tx_xfer) begin
                        if (op == OP_ACK)       state <= S_IDLE;
                        else if (op == OP_EXEC) state <= S_RUN;
                        else if (len == '0)     state <= S_TX_EOT;
                        else if (op == OP_READ) state <= S_RD_REQ;
                        else                    state <= S_WR_DATA;
                    end
                end
                S_WR_DATA: begin
                    if (rx_xfer) begin
                        wdata <= rx_data_i;
                        state <= S_WR_REQ;
                    end
                end
                S_WR_REQ: begin
                    if (mem_gnt_i) begin
                        addr  <= addr + AW'(1);
                        cnt   <= cnt_inc;
                        state <= (cnt_inc == len) ? S_TX_EOT : S_WR_DATA;
                    end
                end
                S_RD_REQ: begin
                    if (mem_gnt_i) state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (mem_rvalid_i) begin
                        rdata <= mem_rdata_i;
                        state <= S_RD_TX;
                    end
                end
                S_RD_TX: begin
                    if (tx_xfer) begin
                        addr  <= addr + AW'(1);
                        cnt   <= cnt_inc;
                        state <= (cnt_inc == len) ? S_TX_EOT : S_RD_REQ;
                    end
                end
                S_TX_EOT: begin
                    if (tx_xfer) state <= S_IDLE;
                end
                S_RUN: begin
                    if (exec_done_i) begin
                        code  <= exec_code_i;
                        state <= S_TX_EOC;
                    end
                end
                S_TX_EOC: begin
                    if (tx_xfer) begin
                        idx   <= '0;
                        state <= S_TX_CODE;
                    end
                end
                S_TX_CODE: begin
                    if (tx_xfer) begin
                        code <= code >> 8;
                        if (idx == CODE_LAST) begin
                            idx   <= '0;
                            state <= S_IDLE;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
            // Watchdog abort overrides any parser progress this cycle.
            if (timeout_abort) begin
                state <= S_IDLE;
                idx   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_debug_server_engine.sv
// Directed testbench for uart_debug_server_engine (default 8/8/4-byte fields).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_uart_debug_server_engine;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic        mem_we_o;
    logic [63:0] mem_addr_o;
    logic [7:0]  mem_wdata_o;
    logic        mem_rvalid_i;
    logic [7:0]  mem_rdata_i;
    logic        exec_valid_o;
    logic [63:0] exec_addr_o;
    logic        exec_done_i;
    logic [31:0] exec_code_i;
    logic        busy_o;

    uart_debug_server_engine #(
        .AddrBytes    (8),
        .LenBytes     (8),
        .ExitBytes    (4),
        .TimeoutCycles(300)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rx_data_i   (rx_data_i),
        .rx_valid_i  (rx_valid_i),
        .rx_ready_o  (rx_ready_o),
        .tx_data_o   (tx_data_o),
        .tx_valid_o  (tx_valid_o),
        .tx_ready_i  (tx_ready_i),
        .mem_req_o   (mem_req_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i (mem_rdata_i),
        .exec_valid_o(exec_valid_o),
        .exec_addr_o (exec_addr_o),
        .exec_done_i (exec_done_i),
        .exec_code_i (exec_code_i),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int errors  = 0;

    logic [7:0]  txq[$];
    logic [7:0]  expq[$];
    logic [63:0] alog[$];
    logic [7:0]  dlog[$];
    logic [7:0]  mem[256];
    bit          tx_toggle = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // TX sink: optionally stalls every other cycle and checks data holds during stalls.
    logic       tx_stall = 0;
    logic [7:0] tx_prev  = '0;
    always @(negedge clk_i) begin
        tx_ready_i = tx_toggle ? ~tx_ready_i : 1'b1;
        if (rst_i) tx_stall = 0;
        if (tx_stall && tx_valid_o) check_eq("tx_hold", {56'd0, tx_data_o}, {56'd0, tx_prev});
        tx_stall = tx_valid_o && !tx_ready_i;
        tx_prev  = tx_data_o;
        if (tx_valid_o && tx_ready_i) txq.push_back(tx_data_o);
    end

    // Memory responder: random grant, read data returned the cycle after grant.
    logic        rd_pend  = 0;
    logic [7:0]  rd_byte  = '0;
    logic        req_wait = 0;
    logic [63:0] req_addr = '0;
    always @(negedge clk_i) begin
        mem_rvalid_i = 1'b0;
        if (rd_pend && !rst_i) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = rd_byte;
        end
        rd_pend   = 0;
        mem_gnt_i = 1'b0;
        if (rst_i) begin
            req_wait = 0;
        end else if (mem_req_o) begin
            if (req_wait) check_eq("req_addr_hold", mem_addr_o, req_addr);
            mem_gnt_i = 1'($urandom_range(0, 1));
            if (mem_gnt_i) begin
                alog.push_back(mem_addr_o);
                if (mem_we_o) begin
                    dlog.push_back(mem_wdata_o);
                    mem[mem_addr_o[7:0]] = mem_wdata_o;
                end else begin
                    rd_pend = 1;
                    rd_byte = mem[mem_addr_o[7:0]];
                end
                req_wait = 0;
            end else begin
                req_wait = 1;
                req_addr = mem_addr_o;
            end
        end else begin
            req_wait = 0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        while (!rx_ready_o && n < 1000) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 1000) check_eq("rx_accept_timeout", 64'd1, 64'd0);
        @(negedge clk_i);
        rx_valid_i = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [63:0] a,
                              input logic [63:0] l, input bit with_len);
        send_byte(cmd);
        for (int i = 0; i < 8; i++) send_byte(a[8*i +: 8]);
        if (with_len) for (int i = 0; i < 8; i++) send_byte(l[8*i +: 8]);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy_o && n < 2000) begin
            @(negedge clk_i);
            n++;
        end
        check_eq({tag, "_idle"}, {63'd0, busy_o}, 64'd0);
        repeat (2) @(negedge clk_i);
    endtask

    task automatic check_tx(input string tag);
        check_eq({tag, "_txlen"}, 64'(txq.size()), 64'(expq.size()));
        for (int i = 0; i < expq.size() && i < txq.size(); i++)
            check_eq($sformatf("%s_tx%0d", tag, i), {56'd0, txq[i]}, {56'd0, expq[i]});
    endtask

    task automatic clear_logs();
        txq.delete();
        alog.delete();
        dlog.delete();
    endtask

    initial begin
        int wn;
        int n;
        rst_i = 1'b1; rx_data_i = '0; rx_valid_i = 1'b0; tx_ready_i = 1'b1;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        exec_done_i = 1'b0; exec_code_i = '0;
        foreach (mem[i]) mem[i] = 8'h00;
        mem[8'hFF] = 8'h5A;
        repeat (3) @(negedge clk_i);
        check_eq("rst_busy", {63'd0, busy_o}, 64'd0);
        check_eq("rst_tx_valid", {63'd0, tx_valid_o}, 64'd0);
        check_eq("rst_mem_req", {63'd0, mem_req_o}, 64'd0);
        check_eq("rst_exec_valid", {63'd0, exec_valid_o}, 64'd0);
        check_eq("rst_rx_ready", {63'd0, rx_ready_o}, 64'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check_eq("idle_rx_ready", {63'd0, rx_ready_o}, 64'd1);

        // Junk byte is dropped; ACK challenge answers 0x06.
        clear_logs();
        send_byte(8'h55);
        send_byte(8'h06);
        wait_idle("ack");
        expq = '{8'h06};
        check_tx("ack");

        // WRITE 3 bytes to 0x8000_0000.
        clear_logs();
        send_frame(8'h12, 64'h8000_0000, 64'd3, 1);
        repeat (4) @(negedge clk_i);
        expq = '{8'h06};
        check_tx("wr_ack");
        send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3);
        wait_idle("wr");
        expq = '{8'h06, 8'h04};
        check_tx("wr");
        check_eq("wr_count", 64'(alog.size()), 64'd3);
        for (int i = 0; i < 3 && i < alog.size() && i < dlog.size(); i++) begin
            check_eq($sformatf("wr_addr%0d", i), alog[i], 64'h8000_0000 + 64'(i));
        end
        if (dlog.size() == 3) begin
            check_eq("wr_data0", {56'd0, dlog[0]}, 64'hA1);
            check_eq("wr_data1", {56'd0, dlog[1]}, 64'hB2);
            check_eq("wr_data2", {56'd0, dlog[2]}, 64'hC3);
        end else check_eq("wr_dlog_size", 64'(dlog.size()), 64'd3);

        // READ 3 bytes back with TX stalling every other cycle.
        clear_logs();
        tx_toggle = 1;
        send_frame(8'h11, 64'h8000_0000, 64'd3, 1);
        wait_idle("rd");
        tx_toggle = 0;
        expq = '{8'h06, 8'hA1, 8'hB2, 8'hC3, 8'h04};
        check_tx("rd");

        // READ len=0: no memory traffic.
        clear_logs();
        send_frame(8'h11, 64'h8000_0000, 64'd0, 1);
        wait_idle("rd0");
        expq = '{8'h06, 8'h04};
        check_tx("rd0");
        check_eq("rd0_no_req", 64'(alog.size()), 64'd0);

        // READ wrapping from all-ones to zero.
        clear_logs();
        send_frame(8'h11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1);
        wait_idle("wrap");
        expq = '{8'h06, 8'h5A, 8'hA1, 8'h04};
        check_tx("wrap");
        check_eq("wrap_count", 64'(alog.size()), 64'd2);
        if (alog.size() == 2) begin
            check_eq("wrap_addr0", alog[0], 64'hFFFF_FFFF_FFFF_FFFF);
            check_eq("wrap_addr1", alog[1], 64'h0);
        end

        // EXEC with done in the very first RUN cycle.
        clear_logs();
        send_frame(8'h13, 64'h8000_0080, 64'd0, 0);
        n = 0;
        while (!exec_valid_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        check_eq("exec_valid", {63'd0, exec_valid_o}, 64'd1);
        check_eq("exec_addr", exec_addr_o, 64'h8000_0080);
        check_eq("run_rx_ready", {63'd0, rx_ready_o}, 64'd0);
        exec_done_i = 1'b1;
        exec_code_i = 32'h0000_002A;
        @(negedge clk_i);
        exec_done_i = 1'b0;
        exec_code_i = 32'hDEAD_BEEF;
        wait_idle("exec");
        expq = '{8'h06, 8'h14, 8'h2A, 8'h00, 8'h00, 8'h00};
        check_tx("exec");
        check_eq("exec_drop", {63'd0, exec_valid_o}, 64'd0);

        // Reset in the middle of a WRITE data phase.
        clear_logs();
        send_frame(8'h12, 64'h40, 64'd5, 1);
        send_byte(8'h11);
        send_byte(8'h22);
        rst_i = 1'b1;
        @(negedge clk_i);
        check_eq("mrst_busy", {63'd0, busy_o}, 64'd0);
        check_eq("mrst_mem_req", {63'd0, mem_req_o}, 64'd0);
        check_eq("mrst_mem_addr", mem_addr_o, 64'd0);
        check_eq("mrst_tx_valid", {63'd0, tx_valid_o}, 64'd0);
        check_eq("mrst_rx_ready", {63'd0, rx_ready_o}, 64'd0);
        wn = alog.size();
        txq.delete();
        rst_i = 1'b0;
        repeat (20) @(negedge clk_i);
        check_eq("mrst_no_more_req", 64'(alog.size()), 64'(wn));
        check_eq("mrst_no_tx", 64'(txq.size()), 64'd0);
        send_byte(8'h06);
        wait_idle("post_rst");
        expq = '{8'h06};
        check_tx("post_rst");

`ifdef UART_DBG_TIMEOUT_EN
        // Partial address then silence: abort to IDLE without TX.
        clear_logs();
        send_byte(8'h11);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        n = 0;
        while (busy_o && n < 1000) begin
            @(negedge clk_i);
            n++;
        end
        check_eq("to_idle", {63'd0, busy_o}, 64'd0);
        check_eq("to_not_early", 64'(n >= 250), 64'd1);
        check_eq("to_no_tx", 64'(txq.size()), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
